// File: rtl/button_scan.sv
// Five-button front end: 2-flop synchronisers, per-button debounce, press-edge
// detection with fixed priority, and auto-repeat for a single held direction key.

`ifndef BUTTON_NONE
`define BUTTON_NONE  5'b00000
`endif
`ifndef BUTTON_UP
`define BUTTON_UP    5'b00001
`endif
`ifndef BUTTON_DOWN
`define BUTTON_DOWN  5'b00010
`endif
`ifndef BUTTON_LEFT
`define BUTTON_LEFT  5'b00100
`endif
`ifndef BUTTON_RIGHT
`define BUTTON_RIGHT 5'b01000
`endif
`ifndef BUTTON_MID
`define BUTTON_MID   5'b10000
`endif

module button_scan #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_mid_i,
  output logic [4:0] button_o,
  output logic [4:0] held_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [4:0]      w_raw;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      w_deb;
  logic [4:0]      r_held;
  logic [4:0]      w_press;
  logic [4:0]      w_win;
  logic            w_start;
  logic            w_exit;
  logic            w_fire;
  logic [1:0]      r_state;
  logic [RP_W-1:0] r_rep_cnt;
  logic [4:0]      r_key;
  logic [4:0]      r_button;

  assign w_raw = {btn_mid_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level only moves after sync2 has disagreed with it for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  for (genvar g = 0; g < 5; g++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_lvl;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_lvl <= r_sync2[g];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[g] = r_lvl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held <= '0;
    end else begin
      r_held <= w_deb;
    end
  end

  assign w_press = w_deb & ~r_held;

  always_comb begin
    w_win = `BUTTON_NONE;
    if (w_press[4])      w_win = `BUTTON_MID;
    else if (w_press[0]) w_win = `BUTTON_UP;
    else if (w_press[1]) w_win = `BUTTON_DOWN;
    else if (w_press[2]) w_win = `BUTTON_LEFT;
    else if (w_press[3]) w_win = `BUTTON_RIGHT;
  end

  // Exit/start are judged on the level held_o takes at this edge, so a press
  // that breaks a repeat is both emitted and able to start a fresh one.
  assign w_start = (w_win != `BUTTON_NONE) && !w_win[4] && (w_deb == w_win);
  assign w_exit  = ((w_deb & r_key) == '0) || ((w_deb & ~r_key) != '0);
  assign w_fire  = !w_exit &&
                   (((r_state == ST_DELAY)  && (r_rep_cnt == DELAY_LAST)) ||
                    ((r_state == ST_REPEAT) && (r_rep_cnt == PERIOD_LAST)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rep_cnt <= '0;
      r_key     <= '0;
      r_button  <= `BUTTON_NONE;
    end else begin
      if (w_win != `BUTTON_NONE) r_button <= w_win;
      else if (w_fire)           r_button <= r_key;
      else                       r_button <= `BUTTON_NONE;

      if (w_start) begin
        r_key     <= w_win;
        r_rep_cnt <= '0;
        r_state   <= ST_DELAY;
      end else begin
        case (r_state)
          ST_DELAY: begin
            if (w_exit) begin
              r_state   <= ST_IDLE;
              r_rep_cnt <= '0;
              r_key     <= '0;
            end else if (r_rep_cnt == DELAY_LAST) begin
              r_state   <= ST_REPEAT;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (w_exit) begin
              r_state   <= ST_IDLE;
              r_rep_cnt <= '0;
              r_key     <= '0;
            end else if (r_rep_cnt == PERIOD_LAST) begin
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_rep_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign button_o = r_button;
  assign held_o   = r_held;

endmodule

// File: tb/tb_button_scan.sv
// Directed bench for button_scan: cycle-level behavioural model plus pulse-time
// literals for each scenario.

module tb_button_scan;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_MID   = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_mid = 1'b0;
  logic [4:0] button_o;
  logic [4:0] held_o;

  button_scan #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up_i(b_up),
    .btn_down_i(b_down),
    .btn_left_i(b_left),
    .btn_right_i(b_right),
    .btn_mid_i(b_mid),
    .button_o(button_o),
    .held_o(held_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: sync stages, sample windows per button, debounced/held
  // levels, and the repeat key with the absolute cycle of its next repeat.
  logic [4:0]    m_s1 = '0, m_s2 = '0, m_deb = '0, m_held = '0, m_btn = '0, m_key = '0;
  logic [DB-1:0] m_hist [5];
  int            m_next = 0;

  function automatic logic [4:0] prio(input logic [4:0] p);
    if (p[4]) return B_MID;
    if (p[0]) return B_UP;
    if (p[1]) return B_DOWN;
    if (p[2]) return B_LEFT;
    if (p[3]) return B_RIGHT;
    return B_NONE;
  endfunction

  always @(posedge clk) begin
    logic [4:0] raw, press, newh, win;
    logic       fire;
    cyc++;
    raw = {b_mid, b_right, b_left, b_down, b_up};
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_held = '0; m_btn = '0; m_key = '0;
      m_next = 0;
      for (int b = 0; b < 5; b++) m_hist[b] = '0;
    end else begin
      press = m_deb & ~m_held;
      newh  = m_deb;
      win   = prio(press);
      for (int b = 0; b < 5; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
        if (m_hist[b] == (m_deb[b] ? {DB{1'b0}} : {DB{1'b1}}))
          m_deb[b] = ~m_deb[b];
      end
      m_s2   = m_s1;
      m_s1   = raw;
      m_held = newh;
      fire   = 1'b0;
      if (m_key != '0) begin
        if ((newh & m_key) == '0 || (newh & ~m_key) != '0) m_key = '0;
        else if (cyc == m_next) begin
          fire   = 1'b1;
          m_next = cyc + RP;
        end
      end
      m_btn = (win != '0) ? win : (fire ? m_key : B_NONE);
      if (win != '0 && !win[4] && newh == win) begin
        m_key  = win;
        m_next = cyc + RD;
      end
    end
  end

  int pcnt [5];
  int ptime [5][8];

  task automatic clear_log();
    for (int b = 0; b < 5; b++) pcnt[b] = 0;
  endtask

  function automatic int total();
    int s = 0;
    for (int b = 0; b < 5; b++) s += pcnt[b];
    return s;
  endfunction

  always @(negedge clk) begin
    check("button_o", {27'd0, button_o}, {27'd0, m_btn});
    check("held_o", {27'd0, held_o}, {27'd0, m_held});
    for (int b = 0; b < 5; b++) begin
      if (button_o[b] === 1'b1) begin
        if (pcnt[b] < 8) ptime[b][pcnt[b]] = cyc;
        pcnt[b]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int offs [6];
    offs = '{0, 20, 28, 36, 44, 52};
    clear_log();

    // Reset then idle
    step(3);
    check("rst_held", {27'd0, held_o}, 32'd0);
    check("rst_btn", {27'd0, button_o}, 32'd0);
    rst_n = 1'b1;
    clear_log();
    step(6);
    check("idle_pulses", total(), 0);

    // Clean UP press
    clear_log();
    t = cyc; b_up = 1'b1;
    step(10);
    check("up_count", pcnt[0], 1);
    check("up_time", ptime[0][0], t + 7);
    check("up_held", {31'd0, held_o[0]}, 32'd1);
    b_up = 1'b0;
    step(12);
    check("up_count_rel", pcnt[0], 1);
    check("up_total", total(), 1);
    check("up_held_rel", {27'd0, held_o}, 32'd0);

    // Bouncing RIGHT
    clear_log();
    b_right = 1'b1; step(1);
    b_right = 1'b0; step(1);
    b_right = 1'b1; step(1);
    b_right = 1'b0; step(1);
    t = cyc; b_right = 1'b1;
    step(12);
    check("right_count", pcnt[3], 1);
    check("right_time", ptime[3][0], t + 7);
    check("right_total", total(), 1);
    b_right = 1'b0;
    step(20);

    // MID and LEFT together
    clear_log();
    t = cyc; b_mid = 1'b1; b_left = 1'b1;
    step(40);
    check("mid_count", pcnt[4], 1);
    check("mid_time", ptime[4][0], t + 7);
    check("left_dropped", pcnt[2], 0);
    check("midleft_total", total(), 1);
    b_mid = 1'b0; b_left = 1'b0;
    step(15);

    // DOWN auto-repeat, released so held drops on the next repeat edge
    clear_log();
    t = cyc; b_down = 1'b1;
    step(60);
    b_down = 1'b0;
    step(30);
    check("down_count", pcnt[1], 6);
    for (int k = 0; k < 6; k++) check("down_time", ptime[1][k], t + 7 + offs[k]);
    check("down_total", total(), 6);

    // LEFT pressed while DOWN is repeating
    clear_log();
    t = cyc; b_down = 1'b1;
    step(37);
    b_left = 1'b1;
    step(40);
    check("dl_down_count", pcnt[1], 4);
    for (int k = 0; k < 4; k++) check("dl_down_time", ptime[1][k], t + 7 + offs[k]);
    check("dl_left_count", pcnt[2], 1);
    check("dl_left_time", ptime[2][0], t + 44);
    check("dl_total", total(), 5);
    b_down = 1'b0; b_left = 1'b0;
    step(20);

    // Reset pulsed during DELAY
    clear_log();
    t = cyc; b_down = 1'b1;
    step(17);
    check("pre_rst_held", {27'd0, held_o}, {27'd0, B_DOWN});
    rst_n = 1'b0;
    step(1);
    check("in_rst_held", {27'd0, held_o}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(15);
    b_down = 1'b0;
    step(20);
    check("rd_count", pcnt[1], 2);
    check("rd_first", ptime[1][0], t + 7);
    check("rd_fresh", ptime[1][1], t + 26);
    check("rd_total", total(), 2);

    step(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
